// File: rtl/runahead_queue.sv
// Runahead replay FIFO: holds instructions deferred by issue and re-offers them
// in program order, rotating blocked heads and parking after a fruitless pass.
module runahead_queue #(
    parameter int DATABITWIDTH = 16,
    parameter int DEPTH        = 8,
    parameter int PTRBITWIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    sync_rst_n,
    input  logic                    clk_en,
    input  logic                    Flush,
    input  logic                    DrainRequest,
    input  logic                    Enq_Valid,
    output logic                    Enq_Ready,
    input  logic [DATABITWIDTH-1:0] Enq_Instruction,
    input  logic [3:0]              Enq_DestReg,
    output logic                    Deq_Valid,
    input  logic                    Deq_Ready,
    input  logic                    Deq_Requeue,
    output logic [DATABITWIDTH-1:0] Deq_Instruction,
    output logic [3:0]              Deq_DestReg,
    output logic [PTRBITWIDTH:0]    Count,
    output logic [1:0]              State
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DRAIN   = 2'b10,
        PARKED  = 2'b11
    } state_t;

    localparam int EW = DATABITWIDTH + 4;
    localparam logic [PTRBITWIDTH:0] FULL = (PTRBITWIDTH + 1)'(DEPTH);
    localparam logic [PTRBITWIDTH:0] ONE  = (PTRBITWIDTH + 1)'(1);

    logic [EW-1:0]          mem [DEPTH];
    logic [PTRBITWIDTH-1:0] head;
    logic [PTRBITWIDTH-1:0] tail;
    logic [PTRBITWIDTH:0]   count;
    logic [PTRBITWIDTH:0]   rot_count;
    logic [PTRBITWIDTH:0]   rot_inc;
    state_t                 state;

    logic push;
    logic pop;
    logic requeue;
    logic wr_en;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] head_entry;

    assign head_entry = mem[head];

    assign Enq_Ready = (count != FULL) && (state != DRAIN);
    assign Deq_Valid = (state == DRAIN) && (count != '0);

    assign Deq_Instruction = head_entry[EW-1:4];
    assign Deq_DestReg     = head_entry[3:0];
    assign Count           = count;
    assign State           = state;

    // Push and pop/requeue are mutually exclusive: pushes need !DRAIN,
    // dequeue activity needs DRAIN.
    assign push    = Enq_Valid && Enq_Ready;
    assign pop     = Deq_Valid && Deq_Ready;
    assign requeue = Deq_Valid && !Deq_Ready && Deq_Requeue;

    assign rot_inc = (rot_count == FULL) ? FULL : rot_count + ONE;

    assign wr_en = sync_rst_n && clk_en && !Flush && (push || requeue);
    assign wr_data = requeue ? head_entry
                             : {Enq_Instruction, Enq_DestReg};

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rot_count <= '0;
            state     <= IDLE;
        end else if (clk_en) begin
            if (Flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                rot_count <= '0;
                state     <= IDLE;
            end else begin
                if (push) begin
                    tail  <= tail + 1'b1;
                    count <= count + ONE;
                end
                if (pop) begin
                    head      <= head + 1'b1;
                    count     <= count - ONE;
                    rot_count <= '0;
                end
                // A full queue rewrites the slot it just vacated.
                if (requeue) begin
                    head <= head + 1'b1;
                    tail <= tail + 1'b1;
                    if (rot_inc == count) begin
                        rot_count <= '0;
                    end else begin
                        rot_count <= rot_inc;
                    end
                end
                unique case (state)
                    IDLE: begin
                        if (push) begin
                            state <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (DrainRequest) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && count == ONE) begin
                            state <= IDLE;
                        end else if (requeue && rot_inc == count) begin
                            state <= PARKED;
                        end
                    end
                    PARKED: begin
                        if (DrainRequest) begin
                            state <= DRAIN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_runahead_queue.sv
// Directed vector bench for runahead_queue: table of per-cycle stimulus
// with hand-computed post-edge expectations, plus reset corner sequences.
module tb_runahead_queue;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_COL  = 2'b01;
    localparam logic [1:0] S_DRN  = 2'b10;
    localparam logic [1:0] S_PRK  = 2'b11;

    logic        clk = 1'b0;
    logic        sync_rst_n;
    logic        clk_en;
    logic        Flush;
    logic        DrainRequest;
    logic        Enq_Valid;
    logic        Enq_Ready;
    logic [15:0] Enq_Instruction;
    logic [3:0]  Enq_DestReg;
    logic        Deq_Valid;
    logic        Deq_Ready;
    logic        Deq_Requeue;
    logic [15:0] Deq_Instruction;
    logic [3:0]  Deq_DestReg;
    logic [3:0]  Count;
    logic [1:0]  State;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    runahead_queue dut (
        .clk             (clk),
        .sync_rst_n      (sync_rst_n),
        .clk_en          (clk_en),
        .Flush           (Flush),
        .DrainRequest    (DrainRequest),
        .Enq_Valid       (Enq_Valid),
        .Enq_Ready       (Enq_Ready),
        .Enq_Instruction (Enq_Instruction),
        .Enq_DestReg     (Enq_DestReg),
        .Deq_Valid       (Deq_Valid),
        .Deq_Ready       (Deq_Ready),
        .Deq_Requeue     (Deq_Requeue),
        .Deq_Instruction (Deq_Instruction),
        .Deq_DestReg     (Deq_DestReg),
        .Count           (Count),
        .State           (State)
    );

    typedef struct {
        logic        en;
        logic        fl;
        logic        dr;
        logic        ev;
        logic [15:0] ins;
        logic [3:0]  dst;
        logic        rdy;
        logic        rq;
        logic [3:0]  cnt;
        logic [1:0]  st;
        logic        er;
        logic        dv;
        logic        chk;
        logic [15:0] eins;
        logic [3:0]  edst;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic en, input logic fl, input logic dr,
        input logic ev, input logic [15:0] ins, input logic [3:0] dst,
        input logic rdy, input logic rq,
        input logic [3:0] cnt, input logic [1:0] st,
        input logic er, input logic dv,
        input logic chk, input logic [15:0] eins, input logic [3:0] edst
    );
        vec_t v;
        v.en = en; v.fl = fl; v.dr = dr; v.ev = ev;
        v.ins = ins; v.dst = dst; v.rdy = rdy; v.rq = rq;
        v.cnt = cnt; v.st = st; v.er = er; v.dv = dv;
        v.chk = chk; v.eins = eins; v.edst = edst;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic check_outs(input int idx, input logic [3:0] cnt,
                              input logic [1:0] st, input logic er,
                              input logic dv);
        check("count", idx, 32'(Count), 32'(cnt));
        check("state", idx, 32'(State), 32'(st));
        check("enq_ready", idx, 32'(Enq_Ready), 32'(er));
        check("deq_valid", idx, 32'(Deq_Valid), 32'(dv));
    endtask

    task automatic idle_inputs();
        clk_en = 1'b1; Flush = 1'b0; DrainRequest = 1'b0;
        Enq_Valid = 1'b0; Enq_Instruction = '0; Enq_DestReg = '0;
        Deq_Ready = 1'b0; Deq_Requeue = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clk_en = v.en; Flush = v.fl; DrainRequest = v.dr;
        Enq_Valid = v.ev; Enq_Instruction = v.ins; Enq_DestReg = v.dst;
        Deq_Ready = v.rdy; Deq_Requeue = v.rq;
        @(posedge clk);
        #1;
        check_outs(idx, v.cnt, v.st, v.er, v.dv);
        if (v.chk) begin
            check("deq_ins", idx, 32'(Deq_Instruction), 32'(v.eins));
            check("deq_dst", idx, 32'(Deq_DestReg), 32'(v.edst));
        end
    endtask

    initial begin
        // First three pushes, drain, in-order pops back to IDLE
        add(1,0,0,1,16'h1111,1,0,0, 1,S_COL,1,0, 0,0,0);
        add(1,0,0,1,16'h2222,2,0,0, 2,S_COL,1,0, 0,0,0);
        add(1,0,0,1,16'h3333,3,0,0, 3,S_COL,1,0, 0,0,0);
        add(1,0,1,0,0,0,0,0,        3,S_DRN,0,1, 1,16'h1111,1);
        add(1,0,0,0,0,0,1,0,        2,S_DRN,0,1, 1,16'h2222,2);
        add(1,0,0,0,0,0,1,0,        1,S_DRN,0,1, 1,16'h3333,3);
        add(1,0,0,0,0,0,1,0,        0,S_IDLE,1,0, 0,0,0);
        // DrainRequest in IDLE does nothing
        add(1,0,1,0,0,0,0,0,        0,S_IDLE,1,0, 0,0,0);
        // Fill to DEPTH across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            add(1,0,0,1,16'hA000 + 16'(i),4'(i),0,0,
                4'(i + 1),S_COL,(i < 7),0, 0,0,0);
        end
        // Ninth push dropped
        add(1,0,0,1,16'hBEEF,15,0,0, 8,S_COL,0,0, 0,0,0);
        add(1,0,1,0,0,0,0,0,         8,S_DRN,0,1, 1,16'hA000,0);
        // Full rotation parks the queue
        for (int k = 1; k <= 8; k++) begin
            add(1,0,0,0,0,0,0,1, 8,(k == 8) ? S_PRK : S_DRN,0,(k < 8),
                1,16'hA000 + 16'(k % 8),4'(k % 8));
        end
        add(1,0,1,0,0,0,0,0, 8,S_DRN,0,1, 1,16'hA000,0);
        for (int k = 1; k <= 5; k++) begin
            add(1,0,0,0,0,0,1,0, 4'(8 - k),S_DRN,0,1,
                1,16'hA000 + 16'(k),4'(k));
        end
        // Requeue then pop with 3 entries: pops original second entry
        add(1,0,0,0,0,0,0,1, 3,S_DRN,0,1, 1,16'hA006,6);
        add(1,0,0,0,0,0,1,0, 2,S_DRN,0,1, 1,16'hA007,7);
        // RotateCount restarted: takes two requeues to park
        add(1,0,0,0,0,0,0,1, 2,S_DRN,0,1, 1,16'hA005,5);
        add(1,0,0,0,0,0,0,1, 2,S_PRK,1,0, 1,16'hA007,7);
        // Push while parked appends behind parked entries
        add(1,0,0,1,16'hC0DE,5,0,0, 3,S_PRK,1,0, 1,16'hA007,7);
        add(1,0,1,0,0,0,0,0, 3,S_DRN,0,1, 1,16'hA007,7);
        add(1,0,0,0,0,0,1,0, 2,S_DRN,0,1, 1,16'hA005,5);
        add(1,0,0,0,0,0,1,0, 1,S_DRN,0,1, 1,16'hC0DE,5);
        add(1,0,0,0,0,0,1,0, 0,S_IDLE,1,0, 0,0,0);
        // Five entries in DRAIN, gated flush/pop ignored, then flush
        for (int i = 0; i < 5; i++) begin
            add(1,0,0,1,16'hD000 + 16'(i),4'(8 + i),0,0,
                4'(i + 1),S_COL,1,0, 0,0,0);
        end
        add(1,0,1,0,0,0,0,0, 5,S_DRN,0,1, 1,16'hD000,8);
        add(0,1,0,0,0,0,1,0, 5,S_DRN,0,1, 1,16'hD000,8);
        add(1,1,0,0,0,0,1,0, 0,S_IDLE,1,0, 0,0,0);
        // Push in same cycle as DrainRequest is kept before draining
        add(1,0,0,1,16'hE001,1,0,0, 1,S_COL,1,0, 0,0,0);
        add(1,0,1,1,16'hE002,2,0,0, 2,S_DRN,0,1, 1,16'hE001,1);
        add(1,0,0,0,0,0,1,0,        1,S_DRN,0,1, 1,16'hE002,2);
        add(1,0,0,0,0,0,1,0,        0,S_IDLE,1,0, 0,0,0);

        idle_inputs();
        sync_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs(-1, 0, S_IDLE, 1, 0);
        @(negedge clk);
        sync_rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i], i);
        end

        // Reset while clk_en is low still clears the queue
        @(negedge clk);
        idle_inputs();
        Enq_Valid = 1'b1; Enq_Instruction = 16'hF00D; Enq_DestReg = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        check_outs(100, 2, S_COL, 1, 0);
        @(negedge clk);
        idle_inputs();
        clk_en = 1'b0;
        sync_rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_outs(101, 0, S_IDLE, 1, 0);
        @(negedge clk);
        sync_rst_n = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check_outs(102, 0, S_IDLE, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
